// File: rtl/spi_master.sv
// SPI initiator, mode 0 (CPOL=0, CPHA=0), MSB-first.
// A single transfer of 1..DATA_W bits is started by a valid/ready request
// and its received bits are returned on a valid/ready response. sck, ss_n
// and mosi are all driven directly from flops.
`timescale 1ns/1ps
module spi_master #(
  parameter int DATA_W  = 32,
  parameter int NSS     = 8,
  parameter int CLK_DIV = 2
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [DATA_W-1:0]       req_data,
  input  logic [$clog2(DATA_W):0] req_len,
  input  logic [NSS-1:0]          req_ss,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_W-1:0]       resp_data,
  output logic                    sck,
  output logic [NSS-1:0]          ss_n,
  output logic                    mosi,
  input  logic                    miso
);

  localparam int LEN_W = $clog2(DATA_W) + 1;
  // Divider counts 0..CLK_DIV-1; keep at least one bit for CLK_DIV=1.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t             state;
  state_t             state_d;

  logic [DATA_W-1:0]  shreg;
  logic [DATA_W-1:0]  rx;
  logic [LEN_W-1:0]   bitcnt;
  logic [LEN_W-1:0]   len_q;
  logic [DIV_W-1:0]   div_cnt;

  logic               accept;
  logic               div_done;
  logic               last_bit;
  logic               active;
  logic [LEN_W-1:0]   eff_len;
  logic [DATA_W-1:0]  load_val;
  logic [DATA_W-1:0]  shifted;
  logic [DATA_W-1:0]  rx_sampled;

  // Request handshake and phase-timing helpers.
  always_comb begin
    accept     = req_valid && req_ready;
    div_done   = (div_cnt == DIV_W'(CLK_DIV - 1));
    last_bit   = ((bitcnt + 1'b1) == len_q);
    active     = (state == SETUP) || (state == HIGH) ||
                 (state == LOW)   || (state == HOLD);
    shifted    = shreg << 1;
    rx_sampled = {rx[DATA_W-2:0], miso};
  end

  // Length clamp: zero or oversize requests mean a full DATA_W-bit transfer.
  // The transmit word is left-aligned so the next bit is always at the MSB.
  always_comb begin
    eff_len = req_len;
    if ((req_len == '0) || (req_len > LEN_W'(DATA_W))) begin
      eff_len = LEN_W'(DATA_W);
    end
    load_val = req_data << (LEN_W'(DATA_W) - eff_len);
  end

  // FSM state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // FSM next-state logic: every active phase lasts one divider period.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept)   state_d = SETUP;
      SETUP:   if (div_done) state_d = HIGH;
      HIGH:    if (div_done) state_d = last_bit ? HOLD : LOW;
      LOW:     if (div_done) state_d = HIGH;
      HOLD:    if (div_done) state_d = RESP;
      RESP:    if (resp_valid && resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Half-period divider: free-runs only while the bus is active.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      div_cnt <= '0;
    end else if (active && !div_done) begin
      div_cnt <= div_cnt + 1'b1;
    end else begin
      div_cnt <= '0;
    end
  end

  // Request ready is registered so it stays low during reset and only
  // returns the cycle after the response handshake.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      req_ready <= 1'b0;
    end else begin
      req_ready <= (state_d == IDLE);
    end
  end

  // Bus pins, shift registers and response: all updated at phase exits.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sck        <= 1'b0;
      ss_n       <= '1;
      mosi       <= 1'b1;
      shreg      <= '0;
      rx         <= '0;
      bitcnt     <= '0;
      len_q      <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            len_q  <= eff_len;
            shreg  <= load_val;
            mosi   <= load_val[DATA_W-1];
            ss_n   <= ~req_ss;
            // Clearing rx keeps the bits above L-1 at zero after L shifts.
            rx     <= '0;
            bitcnt <= '0;
            sck    <= 1'b0;
          end
        end
        SETUP: begin
          if (div_done) begin
            sck <= 1'b1;
            rx  <= rx_sampled;
          end
        end
        HIGH: begin
          if (div_done) begin
            sck <= 1'b0;
            if (!last_bit) begin
              // Next bit launches on the falling edge.
              shreg  <= shifted;
              mosi   <= shifted[DATA_W-1];
              bitcnt <= bitcnt + 1'b1;
            end
          end
        end
        LOW: begin
          if (div_done) begin
            sck <= 1'b1;
            rx  <= rx_sampled;
          end
        end
        HOLD: begin
          if (div_done) begin
            ss_n       <= '1;
            mosi       <= 1'b1;
            resp_data  <= rx;
            resp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
          end
        end
        default: begin
          sck  <= 1'b0;
          ss_n <= '1;
          mosi <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: three instances (CLK_DIV = 1, 2, 3) share one clock
// and reset. A table of directed transfers is applied in a loop, followed by
// hand-written backpressure, mid-transfer reset and bit-reversal slave cases.
`timescale 1ns/1ps
module tb_spi_master;

  localparam int NI = 3;

  logic        clock = 1'b0;
  logic        resetn;

  logic        req_valid  [NI];
  logic        req_ready  [NI];
  logic [31:0] req_data   [NI];
  logic [5:0]  req_len    [NI];
  logic [7:0]  req_ss     [NI];
  logic        resp_valid [NI];
  logic        resp_ready [NI];
  logic [31:0] resp_data  [NI];
  logic        sck        [NI];
  logic [7:0]  ss_n       [NI];
  logic        mosi       [NI];
  logic        miso       [NI];

  // miso source per instance: 0 loopback, 1 tied low, 2 tied high, 3 mock.
  int          mmode      [NI];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    spi_master #(.DATA_W(32), .NSS(8), .CLK_DIV(g + 1)) u_dut (
      .clock      (clock),
      .resetn     (resetn),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_data   (req_data[g]),
      .req_len    (req_len[g]),
      .req_ss     (req_ss[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_data  (resp_data[g]),
      .sck        (sck[g]),
      .ss_n       (ss_n[g]),
      .mosi       (mosi[g]),
      .miso       (miso[g])
    );
  end

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Bit-reversal slave on instance 1, select line 2: it captures the first
  // 8 bits, then shifts the reversed byte back out MSB-first, changing miso
  // after each falling sck edge.
  logic       msck = 1'b0;
  logic [7:0] msh  = 8'h00;
  logic [7:0] mtx  = 8'h00;
  int         mcnt = 0;

  always @(posedge clock) begin
    msck <= sck[1];
    if (ss_n[1][2]) begin
      mcnt <= 0;
      mtx  <= 8'h00;
      msh  <= 8'h00;
    end else begin
      if (sck[1] && !msck) begin
        if (mcnt < 8) msh <= {msh[6:0], mosi[1]};
        mcnt <= mcnt + 1;
      end
      if (!sck[1] && msck) begin
        if (mcnt == 8)     mtx <= bitrev8(msh);
        else if (mcnt > 8) mtx <= mtx << 1;
      end
    end
  end

  always_comb begin
    for (int g = 0; g < NI; g++) begin
      miso[g] = 1'b0;
      case (mmode[g])
        0:       miso[g] = mosi[g];
        1:       miso[g] = 1'b0;
        2:       miso[g] = 1'b1;
        default: miso[g] = mtx[7];
      endcase
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input int g);
    int n = 0;
    @(negedge clock);
    while (!req_ready[g] && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("ready_wait", {31'b0, req_ready[g]}, 32'd1);
  endtask

  // Issue one request and observe until resp_valid (bounded). Returns the
  // cycle count from the accepting edge, sck rising edges, sck-high cycles,
  // ss_n-low cycles, the ss_n value right after accept, the response word
  // and whether mosi was high at every rising edge.
  task automatic run_xfer(input int g, input logic [31:0] d, input logic [5:0] len,
                          input logic [7:0] ss, output int lat, output int edges,
                          output int hi, output int low, output logic [7:0] ssv,
                          output logic [31:0] rdata, output logic mosi_hi);
    logic prev;
    wait_ready(g);
    req_valid[g] = 1'b1;
    req_data[g]  = d;
    req_len[g]   = len;
    req_ss[g]    = ss;
    @(posedge clock); #1;
    req_valid[g] = 1'b0;
    req_data[g]  = ~d;
    req_len[g]   = 6'd3;
    req_ss[g]    = ~ss;
    lat = 0; edges = 0; hi = 0; low = 0; mosi_hi = 1'b1;
    ssv  = ss_n[g];
    prev = sck[g];
    if (ss_n[g] != 8'hFF) low++;
    while (!resp_valid[g] && lat < 2000) begin
      @(posedge clock); #1;
      lat++;
      if (sck[g] && !prev) begin
        edges++;
        if (!mosi[g]) mosi_hi = 1'b0;
      end
      if (sck[g]) hi++;
      prev = sck[g];
      if (!resp_valid[g] && ss_n[g] != 8'hFF) low++;
    end
    rdata = resp_data[g];
  endtask

  typedef struct {
    int          inst;
    logic [31:0] d;
    logic [5:0]  len;
    logic [7:0]  ss;
    int          mm;
    logic [31:0] exp_d;
    int          exp_lat;
    int          exp_edges;
    int          exp_hi;
    int          exp_low;
    logic [7:0]  exp_ssv;
    bit          chk_mosi;
  } vec_t;

  vec_t vt [8];

  initial begin
    int lat, edges, hi, low, n, e;
    logic [7:0]  ssv;
    logic [31:0] rdata, held;
    logic        mhi, prev, pmiso, expb;
    logic [31:0] exp_resp;

    //            inst d             len    ss     mm exp_d         lat  edg hi  low  ssv    mosi
    vt[0] = '{0, 32'h000000A5, 6'd8,  8'h01, 0, 32'h000000A5, 17,  8,  8,  17,  8'hFE, 1'b0};
    vt[1] = '{2, 32'h00000005, 6'd4,  8'h02, 2, 32'h0000000F, 27,  4,  12, 27,  8'hFD, 1'b0};
    vt[2] = '{1, 32'hFFFFFFFF, 6'd0,  8'h80, 1, 32'h00000000, 130, 32, 64, 130, 8'h7F, 1'b1};
    vt[3] = '{1, 32'hFFFFFFFF, 6'd40, 8'h80, 1, 32'h00000000, 130, 32, 64, 130, 8'h7F, 1'b1};
    vt[4] = '{0, 32'h00000001, 6'd1,  8'h10, 0, 32'h00000001, 3,   1,  1,  3,   8'hEF, 1'b0};
    vt[5] = '{0, 32'hDEADBEEF, 6'd32, 8'h01, 0, 32'hDEADBEEF, 65,  32, 32, 65,  8'hFE, 1'b0};
    vt[6] = '{2, 32'hFFFFFABC, 6'd12, 8'h20, 0, 32'h00000ABC, 75,  12, 36, 75,  8'hDF, 1'b0};
    vt[7] = '{1, 32'h00000000, 6'd5,  8'h00, 2, 32'h0000001F, 22,  5,  10, 0,   8'hFF, 1'b0};

    for (int g = 0; g < NI; g++) begin
      req_valid[g]  = 1'b0;
      req_data[g]   = 32'h0;
      req_len[g]    = 6'd0;
      req_ss[g]     = 8'h00;
      resp_ready[g] = 1'b1;
      mmode[g]      = 0;
    end

    // Reset state.
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_sck",        {31'b0, sck[0]},        32'd0);
    check("rst_ss_n",       {24'b0, ss_n[0]},       32'hFF);
    check("rst_mosi",       {31'b0, mosi[0]},       32'd1);
    check("rst_req_ready",  {31'b0, req_ready[0]},  32'd0);
    check("rst_resp_valid", {31'b0, resp_valid[0]}, 32'd0);
    check("rst_resp_data",  resp_data[0],           32'd0);
    check("rst_ss_n_d3",    {24'b0, ss_n[2]},       32'hFF);
    resetn = 1'b1;

    // Directed transfer table.
    for (int i = 0; i < 8; i++) begin
      mmode[vt[i].inst] = vt[i].mm;
      run_xfer(vt[i].inst, vt[i].d, vt[i].len, vt[i].ss, lat, edges, hi, low, ssv, rdata, mhi);
      check($sformatf("v%0d_resp_data", i), rdata, vt[i].exp_d);
      check($sformatf("v%0d_latency", i), lat, vt[i].exp_lat);
      check($sformatf("v%0d_sck_edges", i), edges, vt[i].exp_edges);
      check($sformatf("v%0d_sck_high", i), hi, vt[i].exp_hi);
      check($sformatf("v%0d_ss_low", i), low, vt[i].exp_low);
      check($sformatf("v%0d_ss_n", i), {24'b0, ssv}, {24'b0, vt[i].exp_ssv});
      if (vt[i].chk_mosi) check($sformatf("v%0d_mosi_high", i), {31'b0, mhi}, 32'd1);
    end

    // Backpressure on the D=1 instance.
    mmode[0] = 0;
    resp_ready[0] = 1'b0;
    run_xfer(0, 32'h5A, 6'd8, 8'h01, lat, edges, hi, low, ssv, held, mhi);
    check("bp_first_data", held, 32'h5A);
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      check("bp_valid", {31'b0, resp_valid[0]}, 32'd1);
      check("bp_data",  resp_data[0], held);
      check("bp_ready", {31'b0, req_ready[0]}, 32'd0);
      check("bp_sck",   {31'b0, sck[0]}, 32'd0);
      check("bp_ss_n",  {24'b0, ss_n[0]}, 32'hFF);
    end
    @(negedge clock);
    resp_ready[0] = 1'b1;
    req_valid[0]  = 1'b1;
    req_data[0]   = 32'h3C;
    req_len[0]    = 6'd8;
    req_ss[0]     = 8'h02;
    @(posedge clock); #1;
    check("bp_hs_valid", {31'b0, resp_valid[0]}, 32'd0);
    check("bp_hs_ss_n",  {24'b0, ss_n[0]}, 32'hFF);
    check("bp_hs_ready", {31'b0, req_ready[0]}, 32'd1);
    @(posedge clock); #1;
    req_valid[0] = 1'b0;
    check("bp_acc_ss_n",  {24'b0, ss_n[0]}, 32'hFD);
    check("bp_acc_ready", {31'b0, req_ready[0]}, 32'd0);
    n = 0;
    while (!resp_valid[0] && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    check("bp_next_latency", n, 17);
    check("bp_next_data", resp_data[0], 32'h3C);

    // Asynchronous reset after the third sck rising edge.
    wait_ready(0);
    req_valid[0] = 1'b1;
    req_data[0]  = 32'h96;
    req_len[0]   = 6'd8;
    req_ss[0]    = 8'h01;
    @(posedge clock); #1;
    req_valid[0] = 1'b0;
    e = 0; n = 0; prev = sck[0];
    while (e < 3 && n < 100) begin
      @(posedge clock); #1;
      n++;
      if (sck[0] && !prev) e++;
      prev = sck[0];
    end
    check("rr_third_edge", e, 3);
    check("rr_mosi_before", {31'b0, mosi[0]}, 32'd0);
    #1 resetn = 1'b0;
    #1;
    check("rr_sck",        {31'b0, sck[0]},        32'd0);
    check("rr_ss_n",       {24'b0, ss_n[0]},       32'hFF);
    check("rr_mosi",       {31'b0, mosi[0]},       32'd1);
    check("rr_resp_valid", {31'b0, resp_valid[0]}, 32'd0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock); #1;
      check("rr_no_partial", {31'b0, resp_valid[0]}, 32'd0);
    end
    run_xfer(0, 32'h3C, 6'd8, 8'h01, lat, edges, hi, low, ssv, rdata, mhi);
    check("rr_after_data", rdata, 32'h3C);
    check("rr_after_latency", lat, 17);

    // Bit-reversal slave on instance 1 (D=2), select line 2, L=16.
    mmode[1] = 3;
    wait_ready(1);
    req_valid[1] = 1'b1;
    req_data[1]  = 32'h8001;
    req_len[1]   = 6'd16;
    req_ss[1]    = 8'h04;
    @(posedge clock); #1;
    req_valid[1] = 1'b0;
    exp_resp = 32'h0;
    e = 0; n = 0; prev = sck[1]; pmiso = miso[1];
    while (!resp_valid[1] && n < 500) begin
      @(posedge clock); #1;
      n++;
      if (sck[1] && !prev) begin
        // Reference: zeros during the first byte, then the first byte sent
        // (0x80) bit-reversed, MSB-first.
        if (e < 8) expb = 1'b0;
        else       expb = bitrev8(8'h80) >> (15 - e);
        exp_resp = {exp_resp[30:0], expb};
        check($sformatf("mock_edge%0d", e), {31'b0, pmiso}, {31'b0, expb});
        e++;
      end
      prev  = sck[1];
      pmiso = miso[1];
    end
    check("mock_edges", e, 16);
    check("mock_latency", n, 66);
    check("mock_resp_model", resp_data[1], exp_resp);
    check("mock_resp_const", resp_data[1], 32'h0001);

    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
